// File: rtl/uart_link_tx_arbiter.sv
// rtl/uart_link_tx_arbiter.sv - frame-atomic two-source arbiter in front of one uart_tx
//
// Purpose:
//    Shares a single uart_tx byte transmitter between two frame sources
//    (source 0 = initiator-side requests, source 1 = target-side responses).
//    Each frame goes out prefixed with a channel tag byte. Sources are
//    arbitrated round-robin only at frame boundaries. A frame whose source
//    stalls mid-frame is closed with ABORT_BYTE.
//
// Ports:
//    clk, rst       system clock, synchronous active-high reset
//    s_valid[1:0]   per-source byte valid
//    s_data[15:0]   source i byte on [8i+7:8i]
//    s_last[1:0]    per-source last-byte-of-frame flag
//    s_ready[1:0]   per-source ready, registered, at most one bit set
//    tx_data[7:0]   byte to uart_tx, registered
//    tx_start       one-cycle start pulse to uart_tx, registered
//    tx_busy        uart_tx busy, rises the cycle after tx_start is sampled
//    grant[1:0]     one-hot owner of the current frame, 0 when idle
//    frame_done     one-cycle pulse after the last byte of a frame is started
//    err_timeout    one-cycle pulse, coincident with the abort byte's tx_start

module uart_link_tx_arbiter #(
   parameter logic [7:0] TAG0       = 8'hA0,
   parameter logic [7:0] TAG1       = 8'hB0,
   parameter logic [7:0] ABORT_BYTE = 8'hFF,
   parameter int         TIMEOUT    = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  s_valid,
   input  logic [15:0] s_data,
   input  logic [1:0]  s_last,
   output logic [1:0]  s_ready,
   output logic [7:0]  tx_data,
   output logic        tx_start,
   input  logic        tx_busy,
   output logic [1:0]  grant,
   output logic        frame_done,
   output logic        err_timeout
);

   // The counter never needs to hold TIMEOUT itself: the abort is taken on
   // the edge where it would reach it.
   localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_TAG,
      S_GAP,
      S_FETCH,
      S_SEND,
      S_GAP2,
      S_ABORT
   } state_t;

   state_t        state, state_nxt;
   logic [1:0]    grant_nxt;
   logic [1:0]    s_ready_nxt;
   logic [7:0]    tx_data_nxt;
   logic          tx_start_nxt;
   logic          frame_done_nxt;
   logic          err_timeout_nxt;
   logic          last_winner, last_winner_nxt;
   logic [CW-1:0] to_cnt, to_cnt_nxt;
   logic [7:0]    byte_q, byte_q_nxt;
   logic          last_q, last_q_nxt;

   logic          xfer;
   logic [7:0]    data_sel;
   logic          last_sel;
   logic          pick1;

   // s_ready is only ever driven for the granted source, so any set bit of
   // the AND is the granted source transferring.
   assign xfer     = |(s_valid & s_ready);
   assign data_sel = grant[1] ? s_data[15:8] : s_data[7:0];
   assign last_sel = grant[1] ? s_last[1] : s_last[0];

   // On a tie the source that did not win last time goes; otherwise the
   // only valid source goes.
   assign pick1 = (s_valid == 2'b11) ? ~last_winner : s_valid[1];

   always_comb begin
      state_nxt       = state;
      grant_nxt       = grant;
      s_ready_nxt     = 2'b00;
      tx_data_nxt     = tx_data;
      tx_start_nxt    = 1'b0;
      frame_done_nxt  = 1'b0;
      err_timeout_nxt = 1'b0;
      last_winner_nxt = last_winner;
      to_cnt_nxt      = to_cnt;
      byte_q_nxt      = byte_q;
      last_q_nxt      = last_q;

      case (state)
         S_IDLE: begin
            to_cnt_nxt = '0;
            if (s_valid != 2'b00) begin
               grant_nxt       = pick1 ? 2'b10 : 2'b01;
               last_winner_nxt = pick1;
               state_nxt       = S_TAG;
            end
         end

         S_TAG: begin
            if (!tx_busy) begin
               tx_start_nxt = 1'b1;
               tx_data_nxt  = grant[1] ? TAG1 : TAG0;
               state_nxt    = S_GAP;
            end
         end

         // tx_busy lags tx_start by a cycle; this cycle keeps the FSM from
         // reading the stale low busy right after a start.
         S_GAP: begin
            state_nxt = S_FETCH;
         end

         // Fetching does not look at tx_busy, so the next byte can be
         // buffered while the previous one is still shifting out.
         S_FETCH: begin
            if (xfer) begin
               byte_q_nxt = data_sel;
               last_q_nxt = last_sel;
               to_cnt_nxt = '0;
               state_nxt  = S_SEND;
            end else if (to_cnt == CW'(TIMEOUT - 1)) begin
               to_cnt_nxt = '0;
               state_nxt  = S_ABORT;
            end else begin
               to_cnt_nxt  = to_cnt + CW'(1);
               s_ready_nxt = grant;
            end
         end

         S_SEND: begin
            if (!tx_busy) begin
               tx_start_nxt = 1'b1;
               tx_data_nxt  = byte_q;
               state_nxt    = S_GAP2;
            end
         end

         S_GAP2: begin
            if (last_q) begin
               frame_done_nxt = 1'b1;
               grant_nxt      = 2'b00;
               state_nxt      = S_IDLE;
            end else begin
               state_nxt = S_FETCH;
            end
         end

         S_ABORT: begin
            if (!tx_busy) begin
               tx_start_nxt    = 1'b1;
               tx_data_nxt     = ABORT_BYTE;
               err_timeout_nxt = 1'b1;
               grant_nxt       = 2'b00;
               state_nxt       = S_IDLE;
            end
         end

         default: begin
            grant_nxt = 2'b00;
            state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         grant       <= 2'b00;
         s_ready     <= 2'b00;
         tx_data     <= 8'h00;
         tx_start    <= 1'b0;
         frame_done  <= 1'b0;
         err_timeout <= 1'b0;
         last_winner <= 1'b1;
         to_cnt      <= '0;
         byte_q      <= 8'h00;
         last_q      <= 1'b0;
      end else begin
         state       <= state_nxt;
         grant       <= grant_nxt;
         s_ready     <= s_ready_nxt;
         tx_data     <= tx_data_nxt;
         tx_start    <= tx_start_nxt;
         frame_done  <= frame_done_nxt;
         err_timeout <= err_timeout_nxt;
         last_winner <= last_winner_nxt;
         to_cnt      <= to_cnt_nxt;
         byte_q      <= byte_q_nxt;
         last_q      <= last_q_nxt;
      end
   end

endmodule

// File: tb/tb_uart_link_tx_arbiter.sv
// tb/tb_uart_link_tx_arbiter.sv - self-checking bench for uart_link_tx_arbiter

module tb_uart_link_tx_arbiter;

   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  s_valid;
   logic [15:0] s_data;
   logic [1:0]  s_last;
   logic [1:0]  s_ready;
   logic [7:0]  tx_data;
   logic        tx_start;
   logic        tx_busy;
   logic [1:0]  grant;
   logic        frame_done;
   logic        err_timeout;

   uart_link_tx_arbiter #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
      .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
      .grant(grant), .frame_done(frame_done), .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] d;
      logic       l;
      logic [7:0] dly;
   } ent_t;
   typedef logic [7:0] bq_t [$];

   ent_t       srcq0 [$];
   ent_t       srcq1 [$];
   int         wcnt [2];
   bq_t        obs;
   bq_t        exp_q;
   int         start_cyc [$];
   int         xfer0 [$];
   int         xfer1 [$];
   logic [1:0] gq [$];
   logic [1:0] prev_grant = 2'b00;
   int cyc = 0, busy_cnt = 0, done_cnt = 0, err_cnt = 0, err_cyc = 0;
   int rdy_cyc = 0, bad_rdy = 0;
   logic hold_busy = 1'b0;
   int tests = 0, fails = 0;

   task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
      tests++;
      assert (o === e) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, o, e);
      end
   endtask

   function automatic ent_t head(input int i);
      return (i == 0) ? srcq0[0] : srcq1[0];
   endfunction

   // One clock: sample the DUT at the negedge, then model uart_tx busy and
   // the two sources just after the posedge.
   task automatic tick();
      logic [1:0] xf;
      logic st, rs;
      ent_t h;
      @(negedge clk);
      xf = s_valid & s_ready;
      st = tx_start;
      rs = rst;
      if (tx_start) begin obs.push_back(tx_data); start_cyc.push_back(cyc + 1); end
      if (frame_done) done_cnt++;
      if (err_timeout) begin err_cnt++; err_cyc = cyc + 1; end
      if (grant != 2'b00 && prev_grant == 2'b00) gq.push_back(grant);
      prev_grant = grant;
      if (s_ready != 2'b00) rdy_cyc++;
      if (((s_ready & ~grant) != 2'b00) || (s_ready == 2'b11)) bad_rdy++;
      if (xf[0]) xfer0.push_back(cyc + 1);
      if (xf[1]) xfer1.push_back(cyc + 1);
      @(posedge clk);
      cyc++;
      #1;
      if (st) busy_cnt = 10;
      else if (busy_cnt > 0) busy_cnt--;
      tx_busy = hold_busy | (busy_cnt != 0);
      for (int i = 0; i < 2; i++) begin
         if (rs) begin
            if (i == 0) srcq0.delete(); else srcq1.delete();
            s_valid[i] = 1'b0;
            wcnt[i] = 0;
         end else begin
            if (xf[i]) begin
               if (i == 0) void'(srcq0.pop_front()); else void'(srcq1.pop_front());
               s_valid[i] = 1'b0;
               wcnt[i] = 0;
            end
            if (!s_valid[i] && ((i == 0) ? srcq0.size() : srcq1.size()) > 0) begin
               h = head(i);
               if (wcnt[i] >= int'(h.dly)) begin
                  s_valid[i] = 1'b1;
                  s_data[8*i +: 8] = h.d;
                  s_last[i] = h.l;
               end else begin
                  wcnt[i]++;
               end
            end
         end
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic push_frame(input int src, input bq_t b, input int maxdly);
      ent_t e;
      for (int i = 0; i < b.size(); i++) begin
         e.d   = b[i];
         e.l   = (i == b.size() - 1);
         e.dly = (i == 0) ? 8'd0 : 8'($urandom_range(maxdly, 0));
         if (src == 0) srcq0.push_back(e); else srcq1.push_back(e);
      end
   endtask

   // Reference: a frame on the wire is its channel tag followed by its bytes.
   task automatic add_exp(input int src, input bq_t b);
      exp_q.push_back((src == 0) ? 8'hA0 : 8'hB0);
      foreach (b[i]) exp_q.push_back(b[i]);
   endtask

   function automatic bq_t rand_frame(input int len);
      bq_t q;
      for (int i = 0; i < len; i++) q.push_back(8'($urandom));
      return q;
   endfunction

   task automatic wait_bytes(input string tag, input int n, input int bound);
      int k = 0;
      while (obs.size() < n && k < bound) begin tick(); k++; end
      check(tag, obs.size() >= n, 1);
      run(30);
   endtask

   task automatic check_stream(input string tag, input int base);
      int n;
      check({tag, "_len"}, obs.size() - base, exp_q.size());
      n = (obs.size() - base < exp_q.size()) ? obs.size() - base : exp_q.size();
      for (int i = 0; i < n; i++) check({tag, "_byte"}, obs[base + i], exp_q[i]);
      exp_q.delete();
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      int base, k, sb, xb, gb, db, eb, rb;
      bq_t f0, f1, f2, f3;
      ent_t e;
      rst = 1'b1; s_valid = 2'b00; s_data = 16'h0; s_last = 2'b00; tx_busy = 1'b0;
      wcnt[0] = 0; wcnt[1] = 0;
      run(3);
      check("reset_outputs", {17'd0, s_ready, tx_data, tx_start, grant, frame_done, err_timeout}, 0);
      rst = 1'b0;
      run(2);

      // Single src0 frame, with minimum-latency checks from idle.
      base = obs.size(); sb = start_cyc.size(); xb = xfer0.size(); gb = gq.size(); db = done_cnt;
      k = cyc;
      f0 = {8'h01, 8'h10, 8'hA5};
      push_frame(0, f0, 0);
      add_exp(0, f0);
      wait_bytes("t1_wait", base + 4, 500);
      check_stream("t1", base);
      check("t1_tag_latency", start_cyc[sb], k + 4);
      check("t1_first_xfer", xfer0[xb], k + 6);
      check("t1_done", done_cnt - db, 1);
      check("t1_grants", gq.size() - gb, 1);
      check("t1_grant", gq[gb], 2'b01);
      check("t1_grant_idle", grant, 2'b00);

      // Simultaneous request right after reset: src0 first, no interleave.
      pulse_reset();
      run(2);
      base = obs.size(); gb = gq.size();
      f0 = rand_frame(3); f1 = rand_frame(2);
      push_frame(0, f0, 2); push_frame(1, f1, 2);
      add_exp(0, f0); add_exp(1, f1);
      wait_bytes("t2_wait", base + 7, 800);
      check_stream("t2", base);
      check("t2_order", {gq[gb], gq[gb + 1]}, 4'b0110);
      check("t2_ready_excl", bad_rdy, 0);

      // Continuous 2-byte frames from both sources alternate.
      base = obs.size(); gb = gq.size(); db = done_cnt;
      f0 = rand_frame(2); f1 = rand_frame(2); f2 = rand_frame(2); f3 = rand_frame(2);
      push_frame(0, f0, 0); push_frame(0, f2, 0);
      push_frame(1, f1, 0); push_frame(1, f3, 0);
      add_exp(0, f0); add_exp(1, f1); add_exp(0, f2); add_exp(1, f3);
      wait_bytes("t3_wait", base + 12, 1500);
      check_stream("t3", base);
      check("t3_grant_seq", {gq[gb], gq[gb + 1], gq[gb + 2], gq[gb + 3]}, 8'b01100110);
      check("t3_done", done_cnt - db, 4);

      // Random lengths and intra-frame stalls below the timeout.
      base = obs.size(); db = done_cnt; eb = err_cnt; k = 0;
      for (int i = 0; i < 4; i++) begin
         f0 = rand_frame($urandom_range(4, 1)); f1 = rand_frame($urandom_range(4, 1));
         push_frame(0, f0, 3); push_frame(1, f1, 3);
         add_exp(0, f0); add_exp(1, f1);
         k += f0.size() + f1.size() + 2;
      end
      wait_bytes("t3r_wait", base + k, 4000);
      check_stream("t3r", base);
      check("t3r_done", done_cnt - db, 8);
      check("t3r_no_err", err_cnt - eb, 0);

      // Src1 stalls after one non-last byte: frame aborted with FF.
      base = obs.size(); db = done_cnt; eb = err_cnt; xb = xfer1.size();
      e.d = 8'h22; e.l = 1'b0; e.dly = 8'd0;
      srcq1.push_back(e);
      exp_q = {8'hB0, 8'h22, 8'hFF};
      wait_bytes("t4_wait", base + 3, 800);
      check_stream("t4", base);
      check("t4_err", err_cnt - eb, 1);
      check("t4_no_done", done_cnt - db, 0);
      check("t4_stall_len", (err_cyc - xfer1[xb]) >= TO, 1);
      check("t4_grant_idle", grant, 2'b00);
      base = obs.size(); db = done_cnt;
      f0 = {8'h5A};
      push_frame(0, f0, 0);
      add_exp(0, f0);
      wait_bytes("t4b_wait", base + 2, 500);
      check_stream("t4b", base);
      check("t4b_done", done_cnt - db, 1);

      // tx_busy stuck high in TAG: nothing starts, no timeout, no ready.
      base = obs.size(); sb = start_cyc.size(); eb = err_cnt; rb = rdy_cyc;
      hold_busy = 1'b1; tx_busy = 1'b1;
      f0 = {8'hC3, 8'h3C};
      push_frame(0, f0, 0);
      add_exp(0, f0);
      run(200);
      check("t5_no_start", start_cyc.size() - sb, 0);
      check("t5_no_ready", rdy_cyc - rb, 0);
      check("t5_no_err", err_cnt - eb, 0);
      check("t5_grant", grant, 2'b01);
      k = cyc;
      hold_busy = 1'b0; tx_busy = (busy_cnt != 0);
      wait_bytes("t5_wait", base + 3, 500);
      check("t5_tag_time", start_cyc[sb], k + 2);
      check_stream("t5", base);

      // Reset after the second byte of a 4-byte frame.
      db = done_cnt; xb = xfer0.size(); k = 0;
      f0 = {8'h11, 8'h22, 8'h33, 8'h44};
      push_frame(0, f0, 0);
      while (xfer0.size() < xb + 2 && k < 500) begin tick(); k++; end
      check("t6_two_bytes", xfer0.size() >= xb + 2, 1);
      pulse_reset();
      check("t6_reset_outputs", {17'd0, s_ready, tx_data, tx_start, grant, frame_done, err_timeout}, 0);
      base = obs.size();
      f1 = {8'h77};
      push_frame(1, f1, 0);
      add_exp(1, f1);
      wait_bytes("t6_wait", base + 2, 500);
      check_stream("t6", base);
      check("t6_done", done_cnt - db, 1);
      check("ready_exclusive", bad_rdy, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/uart_link_tx_arbiter.md
Name: uart_link_tx_arbiter

Overview:
- Frame-atomic arbiter sharing one uart_tx byte transmitter between two frame sources in the UART bus bridge.
- Source 0 carries request frames from the initiator-side bridge; source 1 carries response frames from the target-side bridge.
- Prefixes each frame with a channel tag byte so the remote FPGA can demultiplex the link.
- Round-robin between sources at frame boundaries; aborts frames whose source stalls.

Parameters:
TAG0, 8'hA0, tag byte sent before source-0 frames
TAG1, 8'hB0, tag byte sent before source-1 frames
ABORT_BYTE, 8'hFF, byte sent in place of remaining data when a frame times out
TIMEOUT, 1024, cycles of s_valid low mid-frame before abort (>=2)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
s_valid  in  2  per-source byte valid, bit i = source i
s_data  in  16  source i byte at [8i+7:8i]
s_last  in  2  per-source last-byte-of-frame flag
s_ready  out  2  per-source ready; at most one bit set
tx_data  out  8  byte to uart_tx, registered
tx_start  out  1  single-cycle registered start pulse to uart_tx
tx_busy  in  1  uart_tx busy; rises the cycle after tx_start is sampled
grant  out  2  one-hot owner of the current frame; 0 when idle
frame_done  out  1  one-cycle pulse after the last byte of a frame is started
err_timeout  out  1  one-cycle pulse when a frame is aborted

Behaviour:
- Reset values: s_ready=0, tx_data=0, tx_start=0, grant=0, frame_done=0, err_timeout=0, state=IDLE, last_winner=1 (source 0 wins first tie).
- Handshake: a byte transfers on a clk edge where s_valid[i] & s_ready[i]. Sources hold s_data and s_last stable while valid and not ready.
- IDLE:
  - Only one source valid: grant it.
  - Both valid: grant the source other than last_winner.
  - Set grant, update last_winner, go to TAG. The grant is registered: grant becomes visible in the cycle after IDLE samples s_valid.
- TAG: wait for tx_busy=0. At that edge, register tx_start=1 and tx_data=TAGi, then go to GAP.
- GAP: exactly one cycle. tx_start returns to 0, tx_busy is ignored. Go to FETCH.
- FETCH:
  - s_ready[g]=1 (registered). On transfer, latch the byte and s_last, drop s_ready, clear the timeout counter, go to SEND.
  - Each cycle without a transfer increments the timeout counter. On reaching TIMEOUT, go to ABORT.
  - FETCH may accept the next byte while uart_tx is still busy, giving a one-byte prefetch.
- SEND: wait for tx_busy=0, pulse tx_start with the latched byte, go to GAP2.
- GAP2: one cycle.
  - If the latched last=1: pulse frame_done, clear grant, go to IDLE.
  - Otherwise go to FETCH.
- ABORT:
  - Wait for tx_busy=0, pulse tx_start with ABORT_BYTE, and pulse err_timeout in the same cycle as that tx_start.
  - Clear grant, go to IDLE. No frame_done is issued.
- Source behaviour around a frame:
  - The non-granted source sees s_ready=0 for the whole frame, so there is no interleaving within a frame.
  - The granted source with s_valid low in IDLE does not reserve the link.
- Minimum latency, IDLE with tx idle: s_valid sampled at edge N, tx_start (tag) high during cycle N+2, first data byte accepted at edge N+4 at earliest.
- Back-to-back frames: IDLE re-arbitrates the cycle after frame_done. A waiting opposite source wins over the source that just finished.
- A 1-byte frame (s_last on the first byte) is legal: tag plus one byte.
- tx_busy held high indefinitely stalls TAG/SEND/ABORT with no timeout. Timeout applies only to FETCH.
- Reset mid-frame:
  - Returns to IDLE the next cycle with all outputs at reset values. Any partially accepted frame is discarded.
  - A byte already started in uart_tx is not recalled.

Test Plan:
- Src0 frame {0x01,0x10,0xA5} with s_last on 0xA5, tx_busy modelled at 10 cycles/byte -> tx byte sequence A0,01,10,A5; one frame_done; grant=01 throughout, then 00.
- Src0 and src1 valid on the same cycle after reset -> src0 frame (A0,...) fully sent first, then B0 plus src1 bytes; no interleaving; s_ready[1]=0 during the src0 frame.
- Both sources continuously offering 2-byte frames -> grant alternates 01,10,01,10 for 4 frames; frame_done count = 4.
- Src1 sends tag plus byte 0x22 (s_last=0), then s_valid low for TIMEOUT=16 cycles -> tx sequence B0,22,FF; err_timeout pulses once; no frame_done; arbiter returns to IDLE and accepts a new src0 frame.
- tx_busy held high 200 cycles during TAG -> tx_start stays 0, no timeout, no s_ready; tag is sent the cycle after tx_busy falls.
- rst asserted for 1 cycle after the 2nd byte of a 4-byte src0 frame -> all outputs 0 the next cycle; a new src1 frame then starts with tag B0 (last_winner reset to 1).
